// File: rtl/arf_ctrl_pkg.sv
// Shared encodings for the address register file control path:
// FunSel / RegSel / OutSel codes and the fetch sequencer states.
package arf_ctrl_pkg;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;

    // One-cold register enables, bit order {PC, AR, SP}
    localparam logic [2:0] SEL_PC   = 3'b011;
    localparam logic [2:0] SEL_AR   = 3'b101;
    localparam logic [2:0] SEL_SP   = 3'b110;
    localparam logic [2:0] SEL_NONE = 3'b111;

    localparam logic [1:0] OUT_PC = 2'b00;
    localparam logic [1:0] OUT_AR = 2'b10;
    localparam logic [1:0] OUT_SP = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        DONE     = 2'd3
    } fetch_state_e;

    function automatic logic [15:0] place_byte(
        input logic [15:0] cur,
        input logic [7:0]  b,
        input logic        hi
    );
        logic [15:0] r;
        r = cur;
        if (hi) r[15:8] = b;
        else    r[7:0]  = b;
        return r;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/data bundle between the fetch sequencer, the address
// register file and the byte memory.
interface fetch_sequencer_if;

    logic        Start;
    logic        Hold;
    logic        LoadPC;
    logic [15:0] Target;
    logic [7:0]  MemOut;

    logic [15:0] ARF_I;
    logic [2:0]  ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic        Mem_CS;
    logic        Mem_WR;
    logic [15:0] Instr;
    logic        Busy;
    logic        Done;

    modport master (
        input  Start, Hold, LoadPC, Target, MemOut,
        output ARF_I, ARF_FunSel, ARF_RegSel,
        output ARF_OutCSel, ARF_OutDSel,
        output Mem_CS, Mem_WR, Instr, Busy, Done
    );

    modport slave (
        output Start, Hold, LoadPC, Target, MemOut,
        input  ARF_I, ARF_FunSel, ARF_RegSel,
        input  ARF_OutCSel, ARF_OutDSel,
        input  Mem_CS, Mem_WR, Instr, Busy, Done
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetches one 16-bit instruction as two bytes at PC, PC+1,
// bumping PC through the ARF and assembling Instr.
module fetch_sequencer
    import arf_ctrl_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    fetch_sequencer_if.master bus
);

    fetch_state_e r_state;
    fetch_state_e w_next;
    logic [15:0]  r_instr;
    logic         r_done;
    logic         w_capture;
    logic         w_to_hi;

    // Outputs are gated by Reset so they drop to idle values at once
    always_comb begin
        w_next          = r_state;
        w_capture       = 1'b0;
        bus.ARF_I       = 16'h0000;
        bus.ARF_FunSel  = FS_DEC;
        bus.ARF_RegSel  = SEL_NONE;
        bus.ARF_OutCSel = OUT_PC;
        bus.ARF_OutDSel = OUT_PC;
        bus.Mem_CS      = 1'b1;
        bus.Mem_WR      = 1'b0;
        bus.Busy        = 1'b0;
        if (!Reset) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.LoadPC) begin
                        bus.ARF_I      = bus.Target;
                        bus.ARF_FunSel = FS_LOAD;
                        bus.ARF_RegSel = SEL_PC;
                    end else if (bus.Start) begin
                        w_next = FETCH_LO;
                    end
                end
                FETCH_LO, FETCH_HI: begin
                    bus.Busy = 1'b1;
                    if (!bus.Hold) begin
                        bus.Mem_CS     = 1'b0;
                        bus.ARF_FunSel = FS_INC;
                        bus.ARF_RegSel = SEL_PC;
                        w_capture      = 1'b1;
                        w_next = (r_state == FETCH_LO)
                               ? FETCH_HI : DONE;
                    end
                end
                DONE: begin
                    w_next = bus.Start ? FETCH_LO : IDLE;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    // First byte lands in the low half when LOW_FIRST is set
    assign w_to_hi = (r_state == FETCH_LO) ^ LOW_FIRST;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_instr <= 16'h0000;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_capture && (r_state == FETCH_HI);
            if (w_capture) begin
                r_instr <= place_byte(r_instr, bus.MemOut, w_to_hi);
            end
        end
    end

    assign bus.Instr = r_instr;
    assign bus.Done  = r_done;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench: two sequencers (LOW_FIRST=1/0) sharing stimulus, each with
// its own ARF model, over one byte memory; scoreboarded fetches.
module tb_fetch_sequencer;

    typedef enum int {PH_RST, PH_IDLE, PH_FETCH, PH_HOLD, PH_DONE} ph_e;

    typedef struct {
        logic [15:0] i1;
        logic [15:0] i0;
        logic [15:0] pc;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic arf_rst;
    logic start, hold, loadpc;
    logic [15:0] target;
    logic [7:0] mem [65536];
    logic [15:0] pc1, ar1, sp1, pc0, ar0, sp0;
    logic [15:0] a1, a0;
    logic [15:0] pcm;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    ph_e phase;
    exp_t sbq[$];
    logic [28:0] e, m, v1, v0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_sequencer_if b1();
    fetch_sequencer_if b0();

    fetch_sequencer #(.LOW_FIRST(1'b1)) u_dut1 (
        .Clock(clk), .Reset(rst), .bus(b1)
    );
    fetch_sequencer #(.LOW_FIRST(1'b0)) u_dut0 (
        .Clock(clk), .Reset(rst), .bus(b0)
    );

    assign b1.Start  = start;
    assign b0.Start  = start;
    assign b1.Hold   = hold;
    assign b0.Hold   = hold;
    assign b1.LoadPC = loadpc;
    assign b0.LoadPC = loadpc;
    assign b1.Target = target;
    assign b0.Target = target;

    assign a1 = (b1.ARF_OutDSel == 2'b00) ? pc1 :
                (b1.ARF_OutDSel == 2'b10) ? ar1 : sp1;
    assign a0 = (b0.ARF_OutDSel == 2'b00) ? pc0 :
                (b0.ARF_OutDSel == 2'b10) ? ar0 : sp0;
    assign b1.MemOut = mem[a1];
    assign b0.MemOut = mem[a0];

    function automatic logic [15:0] arf_nx(
        input logic [15:0] v, input logic [2:0] fs,
        input logic [15:0] d);
        case (fs)
            3'b000:  return v - 16'd1;
            3'b001:  return v + 16'd1;
            3'b010:  return d;
            3'b011:  return 16'h0000;
            default: return v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (arf_rst) begin
            pc1 <= '0; ar1 <= '0; sp1 <= '0;
            pc0 <= '0; ar0 <= '0; sp0 <= '0;
        end else begin
            if (!b1.ARF_RegSel[2]) pc1 <= arf_nx(pc1, b1.ARF_FunSel, b1.ARF_I);
            if (!b1.ARF_RegSel[1]) ar1 <= arf_nx(ar1, b1.ARF_FunSel, b1.ARF_I);
            if (!b1.ARF_RegSel[0]) sp1 <= arf_nx(sp1, b1.ARF_FunSel, b1.ARF_I);
            if (!b0.ARF_RegSel[2]) pc0 <= arf_nx(pc0, b0.ARF_FunSel, b0.ARF_I);
            if (!b0.ARF_RegSel[1]) ar0 <= arf_nx(ar0, b0.ARF_FunSel, b0.ARF_I);
            if (!b0.ARF_RegSel[0]) sp0 <= arf_nx(sp0, b0.ARF_FunSel, b0.ARF_I);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: bus decode per phase, Done pulses against the scoreboard
    always @(negedge clk) begin
        v1 = {b1.Busy, b1.Mem_CS, b1.ARF_RegSel, b1.ARF_FunSel, b1.Mem_WR,
              b1.ARF_OutCSel, b1.ARF_OutDSel, b1.ARF_I};
        v0 = {b0.Busy, b0.Mem_CS, b0.ARF_RegSel, b0.ARF_FunSel, b0.Mem_WR,
              b0.ARF_OutCSel, b0.ARF_OutDSel, b0.ARF_I};
        m = {1'b1, 1'b1, 3'b111, 3'b000, 1'b1, 4'hF, 16'h0000};
        e = {1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 4'h0, 16'h0000};
        case (phase)
            PH_RST: m = '1;
            PH_IDLE: if (loadpc) begin
                e = {1'b0, 1'b0, 3'b011, 3'b010, 1'b0, 4'h0, target};
                m = {1'b1, 1'b0, 3'b111, 3'b111, 1'b1, 4'hF, 16'hFFFF};
            end
            PH_FETCH: begin
                e = {1'b1, 1'b0, 3'b011, 3'b001, 1'b0, 4'h0, 16'h0000};
                m = {1'b1, 1'b1, 3'b111, 3'b111, 1'b1, 4'hF, 16'h0000};
            end
            PH_HOLD: e = {1'b1, 1'b1, 3'b111, 3'b000, 1'b0, 4'h0, 16'h0000};
            default: ;
        endcase
        chk("bus_lf1", {3'b0, v1 & m}, {3'b0, e & m});
        chk("bus_lf0", {3'b0, v0 & m}, {3'b0, e & m});
        chk("done", {30'b0, b1.Done, b0.Done},
            (phase == PH_DONE) ? 32'd3 : 32'd0);
        if (phase == PH_RST) begin
            chk("rst_instr_lf1", {16'b0, b1.Instr}, 32'h0);
            chk("rst_instr_lf0", {16'b0, b0.Instr}, 32'h0);
        end
        if (b1.Done || b0.Done) begin
            if (sbq.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("done_cyc", cyc, x.cyc);
                chk("instr_lf1", {16'b0, b1.Instr}, {16'b0, x.i1});
                chk("instr_lf0", {16'b0, b0.Instr}, {16'b0, x.i0});
                chk("pc_lf1", {16'b0, pc1}, {16'b0, x.pc});
                chk("pc_lf0", {16'b0, pc0}, {16'b0, x.pc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pc(input logic [15:0] t);
        step();
        phase  = PH_IDLE;
        loadpc = 1'b1;
        target = t;
        start  = 1'($urandom % 2);
        hold   = 1'($urandom % 2);
        pcm    = t;
    endtask

    // Reference: a fetch takes 3 cycles plus one per Hold cycle
    task automatic do_fetches(input int n, input int hl_f, input int hh_f);
        step();
        phase  = PH_IDLE;
        start  = 1'b1;
        loadpc = 1'b0;
        hold   = 1'($urandom % 2);
        for (int k = 0; k < n; k++) begin
            exp_t x;
            int hl, hh, nh;
            logic [15:0] p1;
            hl = (hl_f < 0) ? int'($urandom % 3) : hl_f;
            hh = (hh_f < 0) ? int'($urandom % 3) : hh_f;
            p1 = pcm + 16'd1;
            x.i1  = {mem[p1], mem[pcm]};
            x.i0  = {mem[pcm], mem[p1]};
            x.pc  = pcm + 16'd2;
            x.cyc = cyc + 3 + hl + hh;
            sbq.push_back(x);
            for (int b = 0; b < 2; b++) begin
                nh = (b == 0) ? hl : hh;
                for (int h = 0; h <= nh; h++) begin
                    step();
                    hold   = (h < nh);
                    phase  = hold ? PH_HOLD : PH_FETCH;
                    start  = 1'($urandom % 2);
                    loadpc = 1'($urandom % 2);
                    target = 16'($urandom);
                end
            end
            step();
            phase  = PH_DONE;
            start  = (k < n - 1);
            hold   = 1'($urandom % 2);
            loadpc = 1'($urandom % 2);
            target = 16'($urandom);
            pcm    = pcm + 16'd2;
        end
        step();
        phase  = PH_IDLE;
        start  = 1'b0;
        loadpc = 1'b0;
        hold   = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        rst = 1'b1; arf_rst = 1'b1; phase = PH_RST;
        start = 1'b0; hold = 1'b0; loadpc = 1'b0; target = 16'h0;
        pcm = 16'h0;
        step(); step();
        step();
        rst = 1'b0; arf_rst = 1'b0; phase = PH_IDLE;

        mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
        load_pc(16'h0010);
        do_fetches(1, 0, 0);

        mem[16'h0020] = 8'hAA; mem[16'h0021] = 8'hBB;
        mem[16'h0022] = 8'hCC; mem[16'h0023] = 8'hDD;
        load_pc(16'h0020);
        do_fetches(2, 0, 0);

        load_pc(16'h0100);
        do_fetches(1, 0, 2);

        mem[16'hFFFF] = 8'h01; mem[16'h0000] = 8'h02;
        load_pc(16'hFFFF);
        do_fetches(1, 0, 0);

        // Reset while in FETCH_HI: PC keeps its first increment only
        load_pc(16'h0200);
        step(); phase = PH_IDLE; start = 1'b1; loadpc = 1'b0; hold = 1'b0;
        step(); phase = PH_FETCH; start = 1'b0;
        step(); phase = PH_FETCH;
        #1 rst = 1'b1; phase = PH_RST;
        #1;
        chk("midrst_cs", {31'b0, b1.Mem_CS}, 32'd1);
        chk("midrst_regsel", {29'b0, b1.ARF_RegSel}, 32'd7);
        chk("midrst_busy", {30'b0, b1.Busy, b0.Busy}, 32'd0);
        chk("midrst_instr", {b1.Instr, b0.Instr}, 32'd0);
        step(); step();
        rst = 1'b0; phase = PH_IDLE;
        chk("midrst_pc_lf1", {16'b0, pc1}, 32'h0201);
        chk("midrst_pc_lf0", {16'b0, pc0}, 32'h0201);
        pcm = 16'h0201;
        do_fetches(1, -1, -1);

        for (int it = 0; it < 30; it++) begin
            if ($urandom % 4 == 0) load_pc(16'hFFFE + 16'($urandom % 2));
            else load_pc(16'($urandom));
            do_fetches(1 + int'($urandom % 3), -1, -1);
        end

        step(); step(); step();
        chk("sb_drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
